// File: rtl/serdes_rx_checker.sv
// Checks decoded SERDES RX words against a fixed pattern and tracks link lock.
// Latency: inputs registered once, status/counters one edge later; no backpressure (one word per rx_clk).
module serdes_rx_checker #(
    parameter logic [63:0] EXP_DATA   = 64'h00000000_00CAFEBC,
    parameter logic [7:0]  EXP_K      = 8'h01,
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int          LOCK_CNT   = 8,
    parameter int          UNLOCK_CNT = 4
) (
    input  logic        rx_clk,
    input  logic        rx_rstn_i,
    input  logic [63:0] rx_data_i,
    input  logic [7:0]  rx_char_is_k_i,
    input  logic [7:0]  rx_not_in_table_i,
    input  logic [7:0]  rx_disp_err_i,
    input  logic        cnt_clear_i,
    output logic [1:0]  state_o,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] word_cnt_o,
    output logic [2:0]  comma_lane_o,
    output logic        comma_valid_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        SLIP   = 2'b11
    } state_t;

    localparam logic [7:0] LC = 8'(LOCK_CNT);
    localparam logic [7:0] UC = 8'(UNLOCK_CNT);

    logic [63:0] r_data;
    logic [7:0]  r_k;
    logic [7:0]  r_nit;
    logic [7:0]  r_de;
    state_t      r_state;
    state_t      w_state;
    logic [7:0]  r_run;
    logic [7:0]  r_bad;
    logic [7:0]  w_run;
    logic [7:0]  w_bad;
    logic [7:0]  w_run_inc;
    logic [7:0]  w_bad_inc;
    logic        w_good;
    logic        w_in_lock;
    logic        r_err;
    logic [15:0] r_err_cnt;
    logic [31:0] r_word_cnt;
    logic [2:0]  r_lane;
    logic        r_cvld;
    logic        w_cvld;
    logic [2:0]  w_lane;

    always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_data <= '0;
            r_k    <= '0;
            r_nit  <= '0;
            r_de   <= '0;
        end else begin
            r_data <= rx_data_i;
            r_k    <= rx_char_is_k_i;
            r_nit  <= rx_not_in_table_i;
            r_de   <= rx_disp_err_i;
        end
    end

    assign w_good    = (r_data == EXP_DATA) && (r_k == EXP_K) && (r_nit == 8'h00) && (r_de == 8'h00);
    assign w_in_lock = (r_state == LOCKED) || (r_state == SLIP);
    assign w_run_inc = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
    assign w_bad_inc = (r_bad == 8'hFF) ? r_bad : r_bad + 8'd1;

    always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_state <= HUNT;
            r_run   <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_state;
            r_run   <= w_run;
            r_bad   <= w_bad;
        end
    end

    always_comb begin
        w_state = r_state;
        w_run   = r_run;
        w_bad   = r_bad;
        case (r_state)
            HUNT: begin
                w_run = 8'd0;
                if (w_good) begin
                    if (LC == 8'd1) begin
                        w_state = LOCKED;
                    end else begin
                        w_state = VERIFY;
                        w_run   = 8'd1;
                    end
                end
            end
            VERIFY: begin
                if (w_good) begin
                    if (w_run_inc >= LC) begin
                        w_state = LOCKED;
                        w_run   = 8'd0;
                    end else begin
                        w_run = w_run_inc;
                    end
                end else begin
                    w_state = HUNT;
                    w_run   = 8'd0;
                end
            end
            LOCKED: begin
                w_bad = 8'd0;
                if (!w_good) begin
                    if (UC == 8'd1) begin
                        w_state = HUNT;
                    end else begin
                        w_state = SLIP;
                        w_bad   = 8'd1;
                    end
                end
            end
            default: begin
                if (w_good) begin
                    w_state = LOCKED;
                    w_bad   = 8'd0;
                end else if (w_bad_inc >= UC) begin
                    w_state = HUNT;
                    w_bad   = 8'd0;
                end else begin
                    w_bad = w_bad_inc;
                end
            end
        endcase
    end

    // Clear wins over a coincident increment; err_o still pulses when the count is saturated.
    always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_err <= w_in_lock && !w_good;
            if (cnt_clear_i) begin
                r_err_cnt  <= '0;
                r_word_cnt <= '0;
            end else begin
                if (w_in_lock && (r_word_cnt != 32'hFFFF_FFFF)) begin
                    r_word_cnt <= r_word_cnt + 32'd1;
                end
                if (w_in_lock && !w_good && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_lane = 3'd0;
        w_cvld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r_k[i] && (r_data[8*i +: 8] == COMMA)) begin
                w_lane = 3'(i);
                w_cvld = $onehot(r_k);
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_lane <= '0;
            r_cvld <= 1'b0;
        end else begin
            r_cvld <= w_cvld;
            if (w_cvld) begin
                r_lane <= w_lane;
            end
        end
    end

    assign state_o       = r_state;
    assign locked_o      = w_in_lock;
    assign err_o         = r_err;
    assign err_cnt_o     = r_err_cnt;
    assign word_cnt_o    = r_word_cnt;
    assign comma_lane_o  = r_lane;
    assign comma_valid_o = r_cvld;

endmodule

// File: tb/tb_serdes_rx_checker.sv
// Directed bench for serdes_rx_checker: default-parameter instance plus a LOCK_CNT=1/UNLOCK_CNT=255 instance for saturation.
module tb_serdes_rx_checker;

    localparam logic [63:0] GD = 64'h00000000_00CAFEBC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [63:0] a_data;
    logic [7:0]  a_k, a_nit, a_de;
    logic        a_clr;
    logic [1:0]  a_state;
    logic        a_locked, a_err, a_cvld;
    logic [15:0] a_ecnt;
    logic [31:0] a_wcnt;
    logic [2:0]  a_lane;

    logic [63:0] b_data;
    logic [7:0]  b_k, b_nit, b_de;
    logic        b_clr;
    logic [1:0]  b_state;
    logic        b_locked, b_err, b_cvld;
    logic [15:0] b_ecnt;
    logic [31:0] b_wcnt;
    logic [2:0]  b_lane;

    int tests = 0;
    int fails = 0;

    serdes_rx_checker dut_a (
        .rx_clk(clk), .rx_rstn_i(rstn), .rx_data_i(a_data), .rx_char_is_k_i(a_k),
        .rx_not_in_table_i(a_nit), .rx_disp_err_i(a_de), .cnt_clear_i(a_clr),
        .state_o(a_state), .locked_o(a_locked), .err_o(a_err), .err_cnt_o(a_ecnt),
        .word_cnt_o(a_wcnt), .comma_lane_o(a_lane), .comma_valid_o(a_cvld)
    );

    serdes_rx_checker #(.LOCK_CNT(1), .UNLOCK_CNT(255)) dut_b (
        .rx_clk(clk), .rx_rstn_i(rstn), .rx_data_i(b_data), .rx_char_is_k_i(b_k),
        .rx_not_in_table_i(b_nit), .rx_disp_err_i(b_de), .cnt_clear_i(b_clr),
        .state_o(b_state), .locked_o(b_locked), .err_o(b_err), .err_cnt_o(b_ecnt),
        .word_cnt_o(b_wcnt), .comma_lane_o(b_lane), .comma_valid_o(b_cvld)
    );

    task automatic drv_a(input logic [63:0] d, input logic [7:0] k, input logic [7:0] nit,
                         input logic [7:0] de, input logic clr);
        a_data = d; a_k = k; a_nit = nit; a_de = de; a_clr = clr;
        @(posedge clk); #1;
    endtask

    task automatic drv_b(input logic [63:0] d, input logic [7:0] k, input logic clr);
        b_data = d; b_k = k; b_nit = 8'h00; b_de = 8'h00; b_clr = clr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        a_data = '0; a_k = '0; a_nit = '0; a_de = '0; a_clr = 1'b0;
        b_data = '0; b_k = '0; b_nit = '0; b_de = '0; b_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (a_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0d exp 0", a_state); end
        tests++; if ({a_locked, a_err, a_cvld} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b exp 000", {a_locked, a_err, a_cvld}); end
        tests++; if ({a_ecnt, a_wcnt, a_lane} !== 51'd0) begin fails++; $display("FAIL reset_counts: ecnt=%0d wcnt=%0d lane=%0d exp 0", a_ecnt, a_wcnt, a_lane); end
        tests++; if (b_state !== 2'b00) begin fails++; $display("FAIL reset_state_b: got %0d exp 0", b_state); end
        rstn = 1'b1;
    endtask

    task automatic test_lock;
        repeat (8) drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b01 || a_locked !== 1'b0) begin fails++; $display("FAIL lock_pre: state=%0d locked=%b exp 1/0", a_state, a_locked); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b10 || a_locked !== 1'b1) begin fails++; $display("FAIL lock_state: state=%0d locked=%b exp 2/1", a_state, a_locked); end
        tests++; if (a_cvld !== 1'b1 || a_lane !== 3'd0) begin fails++; $display("FAIL lock_comma: valid=%b lane=%0d exp 1/0", a_cvld, a_lane); end
        tests++; if (a_wcnt !== 32'd0) begin fails++; $display("FAIL lock_wcnt: got %0d exp 0", a_wcnt); end
    endtask

    task automatic test_slip;
        drv_a(GD, 8'h01, 8'h00, 8'h01, 1'b0);
        tests++; if (a_wcnt !== 32'd1 || a_err !== 1'b0) begin fails++; $display("FAIL slip_pre: wcnt=%0d err=%b exp 1/0", a_wcnt, a_err); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b11 || a_err !== 1'b1 || a_ecnt !== 16'd1 || a_locked !== 1'b1) begin
            fails++; $display("FAIL slip_enter: state=%0d err=%b ecnt=%0d locked=%b exp 3/1/1/1", a_state, a_err, a_ecnt, a_locked); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b10 || a_err !== 1'b0 || a_ecnt !== 16'd1 || a_wcnt !== 32'd3) begin
            fails++; $display("FAIL slip_exit: state=%0d err=%b ecnt=%0d wcnt=%0d exp 2/0/1/3", a_state, a_err, a_ecnt, a_wcnt); end
    endtask

    task automatic test_unlock;
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b1);
        tests++; if (a_ecnt !== 16'd0 || a_wcnt !== 32'd0 || a_state !== 2'b10) begin
            fails++; $display("FAIL clear: ecnt=%0d wcnt=%0d state=%0d exp 0/0/2", a_ecnt, a_wcnt, a_state); end
        repeat (4) drv_a(GD, 8'h01, 8'h04, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b11 || a_ecnt !== 16'd3 || a_wcnt !== 32'd4) begin
            fails++; $display("FAIL unlock_mid: state=%0d ecnt=%0d wcnt=%0d exp 3/3/4", a_state, a_ecnt, a_wcnt); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b00 || a_locked !== 1'b0 || a_err !== 1'b1 || a_ecnt !== 16'd4 || a_wcnt !== 32'd5) begin
            fails++; $display("FAIL unlock_hunt: state=%0d locked=%b err=%b ecnt=%0d wcnt=%0d exp 0/0/1/4/5", a_state, a_locked, a_err, a_ecnt, a_wcnt); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b01 || a_wcnt !== 32'd5 || a_err !== 1'b0) begin
            fails++; $display("FAIL unlock_after: state=%0d wcnt=%0d err=%b exp 1/5/0", a_state, a_wcnt, a_err); end
    endtask

    task automatic test_verify_bad;
        repeat (3) drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        drv_a(64'h0, 8'h01, 8'h00, 8'h00, 1'b0);
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b00 || a_ecnt !== 16'd4) begin fails++; $display("FAIL verify_bad: state=%0d ecnt=%0d exp 0/4", a_state, a_ecnt); end
        repeat (7) drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b01) begin fails++; $display("FAIL relock_pre: state=%0d exp 1", a_state); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b10) begin fails++; $display("FAIL relock: state=%0d exp 2", a_state); end
    endtask

    task automatic test_reset_midlock;
        a_data = '0; a_k = '0;
        rstn = 1'b0;
        #1;
        tests++; if (a_state !== 2'b00 || a_locked !== 1'b0 || a_wcnt !== 32'd0 || a_ecnt !== 16'd0 || a_cvld !== 1'b0) begin
            fails++; $display("FAIL async_reset: state=%0d locked=%b wcnt=%0d ecnt=%0d cvld=%b exp all 0", a_state, a_locked, a_wcnt, a_ecnt, a_cvld); end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (8) drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b01) begin fails++; $display("FAIL reset_relock_pre: state=%0d exp 1", a_state); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_state !== 2'b10) begin fails++; $display("FAIL reset_relock: state=%0d exp 2", a_state); end
    endtask

    task automatic test_comma;
        drv_a(64'h0000BC00_00000000, 8'h20, 8'h00, 8'h00, 1'b0);
        drv_a(64'h0000BC00_000000BC, 8'h21, 8'h00, 8'h00, 1'b0);
        tests++; if (a_cvld !== 1'b1 || a_lane !== 3'd5) begin fails++; $display("FAIL comma_lane5: valid=%b lane=%0d exp 1/5", a_cvld, a_lane); end
        drv_a(64'h00000000_001C0000, 8'h04, 8'h00, 8'h00, 1'b0);
        tests++; if (a_cvld !== 1'b0 || a_lane !== 3'd5) begin fails++; $display("FAIL comma_two_k: valid=%b lane=%0d exp 0/5", a_cvld, a_lane); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_cvld !== 1'b0 || a_lane !== 3'd5) begin fails++; $display("FAIL comma_not_bc: valid=%b lane=%0d exp 0/5", a_cvld, a_lane); end
        drv_a(GD, 8'h01, 8'h00, 8'h00, 1'b0);
        tests++; if (a_cvld !== 1'b1 || a_lane !== 3'd0) begin fails++; $display("FAIL comma_lane0: valid=%b lane=%0d exp 1/0", a_cvld, a_lane); end
    endtask

    task automatic test_saturate;
        int driven;
        int run;
        drv_b(GD, 8'h01, 1'b0);
        drv_b(64'h0, 8'h01, 1'b0);
        tests++; if (b_state !== 2'b10) begin fails++; $display("FAIL lock_cnt1: state=%0d exp 2", b_state); end
        driven = 1;
        run = 1;
        while (driven < 65535) begin
            if (run == 200) begin
                drv_b(GD, 8'h01, 1'b0);
                run = 0;
            end else begin
                drv_b(64'h0, 8'h01, 1'b0);
                driven++;
                run++;
            end
        end
        drv_b(GD, 8'h01, 1'b0);
        tests++; if (b_ecnt !== 16'hFFFF || b_err !== 1'b1 || b_locked !== 1'b1) begin
            fails++; $display("FAIL sat_reach: ecnt=%h err=%b locked=%b exp ffff/1/1", b_ecnt, b_err, b_locked); end
        drv_b(64'h0, 8'h01, 1'b0);
        drv_b(GD, 8'h01, 1'b0);
        tests++; if (b_ecnt !== 16'hFFFF || b_err !== 1'b1) begin fails++; $display("FAIL sat_hold: ecnt=%h err=%b exp ffff/1", b_ecnt, b_err); end
        drv_b(64'h0, 8'h01, 1'b0);
        drv_b(GD, 8'h01, 1'b1);
        tests++; if (b_ecnt !== 16'd0 || b_wcnt !== 32'd0 || b_err !== 1'b1) begin
            fails++; $display("FAIL sat_clear: ecnt=%0d wcnt=%0d err=%b exp 0/0/1", b_ecnt, b_wcnt, b_err); end
        drv_b(64'h0, 8'h01, 1'b0);
        drv_b(GD, 8'h01, 1'b0);
        tests++; if (b_ecnt !== 16'd1 || b_wcnt !== 32'd2 || b_state !== 2'b11) begin
            fails++; $display("FAIL post_clear: ecnt=%0d wcnt=%0d state=%0d exp 1/2/3", b_ecnt, b_wcnt, b_state); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_unlock();
        test_verify_bad();
        test_reset_midlock();
        test_comma();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serdes_rx_checker.md
SERDES_RX_CHECKER -- requirements
Module: serdes_rx_checker

Interface
REQ-001 SHALL have parameter EXP_DATA, default 64'h00000000_00CAFEBC, the expected decoded 64-bit RX word.
REQ-002 SHALL have parameter EXP_K, default 8'h01, the expected per-byte K-flag vector.
REQ-003 SHALL have parameter COMMA, default 8'hBC, the comma byte value (K28.5).
REQ-004 SHALL have parameter LOCK_CNT, default 8, legal range 1..255: consecutive good words needed to lock.
REQ-005 SHALL have parameter UNLOCK_CNT, default 4, legal range 1..255: consecutive bad words that drop lock.
REQ-006 SHALL have port rx_clk, input, 1 bit: the single clock (SERDES RX_CLK_O domain).
REQ-007 SHALL have port rx_rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rx_data_i, input, 64 bits: decoded RX data from CC_SERDES RX_DATA_O.
REQ-009 SHALL have port rx_char_is_k_i, input, 8 bits: per-byte K flags.
REQ-010 SHALL have port rx_not_in_table_i, input, 8 bits: per-byte 8b/10b code errors.
REQ-011 SHALL have port rx_disp_err_i, input, 8 bits: per-byte disparity errors.
REQ-012 SHALL have port cnt_clear_i, input, 1 bit: synchronous counter clear.
REQ-013 SHALL have port state_o, output, 2 bits: FSM state.
REQ-014 SHALL have port locked_o, output, 1 bit: link locked.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse per bad word while locked.
REQ-016 SHALL have port err_cnt_o, output, 16 bits: saturating bad-word count.
REQ-017 SHALL have port word_cnt_o, output, 32 bits: saturating checked-word count.
REQ-018 SHALL have port comma_lane_o, output, 3 bits: byte lane of the last detected comma.
REQ-019 SHALL have port comma_valid_o, output, 1 bit: the current word holds exactly one comma.

Function
REQ-020 All inputs SHALL be registered once (stage 1); classification SHALL use stage-1 values only.
REQ-021 A word SHALL be "good" iff data==EXP_DATA, k==EXP_K, not_in_table==0 and disp_err==0; it SHALL otherwise be "bad".
REQ-022 State, counters and outputs SHALL update on the edge after stage-1 capture: an input sampled at edge k is reflected after edge k+1.
REQ-023 States SHALL be encoded HUNT=2'b00, VERIFY=2'b01, LOCKED=2'b10, SLIP=2'b11.
REQ-024 HUNT: on a good word SHALL go to VERIFY with run=1, or directly to LOCKED if LOCK_CNT==1; on a bad word SHALL stay in HUNT.
REQ-025 VERIFY: on a good word SHALL increment run and go to LOCKED when run reaches LOCK_CNT; on a bad word SHALL go to HUNT with run=0.
REQ-026 LOCKED: on a good word SHALL stay; on a bad word SHALL go to SLIP with bad=1, or to HUNT if UNLOCK_CNT==1.
REQ-027 SLIP: on a good word SHALL return to LOCKED with bad=0; on a bad word SHALL increment bad and go to HUNT when bad reaches UNLOCK_CNT.
REQ-028 run/bad counters SHALL be 8 bits and SHALL never wrap.
REQ-029 locked_o SHALL be 1 exactly in LOCKED or SLIP.
REQ-030 word_cnt_o SHALL increment once per word classified in LOCKED or SLIP, saturating at 32'hFFFFFFFF.
REQ-031 err_cnt_o SHALL increment once per bad word classified in LOCKED or SLIP, including the word that causes exit to HUNT, saturating at 16'hFFFF.
REQ-032 err_o SHALL pulse in the same cycle as each err_cnt_o increment condition, including when err_cnt_o is saturated.
REQ-033 cnt_clear_i SHALL zero both counters on the next edge, and SHALL take priority over a simultaneous increment (result 0).
REQ-034 cnt_clear_i SHALL NOT affect state, run or bad.
REQ-035 Comma detect: if exactly one k bit is set and that byte equals COMMA, comma_valid_o SHALL be 1 and comma_lane_o SHALL equal that byte index.
REQ-036 Otherwise comma_valid_o SHALL be 0 and comma_lane_o SHALL hold its previous value.
REQ-037 Comma detect SHALL run in every state.

Reset
REQ-038 Asserting rx_rstn_i low SHALL immediately clear stage-1 registers, run, bad and all outputs: state_o=HUNT, locked_o=0, err_o=0, err_cnt_o=0, word_cnt_o=0, comma_lane_o=0, comma_valid_o=0.
REQ-039 Reset mid-lock SHALL discard all history; relock SHALL require LOCK_CNT fresh good words.

Verification
REQ-040 Reset, then 8 words of 64'h00CAFEBC with k=01 -> locked_o rises 2 edges after the 8th sample; comma_lane_o=0, comma_valid_o=1.
REQ-041 When locked, 1 bad word then good words -> state LOCKED->SLIP->LOCKED; err_cnt_o=1, one err_o pulse.
REQ-042 When locked, 4 consecutive words with not_in_table=8'h04 -> HUNT after the 4th; err_cnt_o=4; word_cnt_o stops incrementing.
REQ-043 In VERIFY at run=5, 1 bad word -> HUNT; 8 further good words are required to lock.
REQ-044 Comma in byte 5 (k=8'h20, data[47:40]=BC) -> comma_lane_o=5; k=8'h21 -> comma_valid_o=0, lane stays 5.
REQ-045 Force err_cnt_o to 16'hFFFF, bad word -> count holds and err_o pulses; cnt_clear_i coincident with increment -> count 0.
